// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with hardware clear sequencer
// Optional pending-writer scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       writeaddr,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [NREAD*ADDR_W-1:0] readaddr,
    output logic [NREAD*DATA_W-1:0] readdata,
    input  logic                    clr,
    output logic                    init_busy,
    output logic                    wr_dropped
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic [NREAD-1:0]        rd_pending
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CTR_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     ctr_q, ctr_d;
    logic                drop_q, drop_d;
    logic                is_clear;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   ra;
    logic                zero_hit;
    logic                fwd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ctr_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            drop_q  <= drop_d;
        end
    end

    // A clr seen while clearing restarts the sweep so the file is fully zeroed after the last request.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr) begin
                    ctr_d = '0;
                end else if (ctr_q == CTR_LAST) begin
                    state_d = ST_READY;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + (ADDR_W+1)'(1);
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ctr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ctr_d   = '0;
            end
        endcase
    end

    always_comb begin
        is_clear  = (state_q == ST_CLEAR);
        init_busy = is_clear;
        wr_dropped = drop_q;
        drop_d    = is_clear && we;
        if (is_clear) begin
            mem_we    = 1'b1;
            mem_waddr = ctr_q[ADDR_W-1:0];
            mem_wdata = '0;
        end else begin
            mem_we    = we && !((ZERO_REG != 0) && (writeaddr == '0));
            mem_waddr = writeaddr;
            mem_wdata = writedata;
        end
    end

    // Gating on rst_n drops any write that coincides with an asserted reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] pend_q, pend_d;

    // Issue is applied after the write-back clear so a same-cycle issue keeps the entry pending.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_READY) begin
            if (we) begin
                pend_d[writeaddr] = 1'b0;
            end
            if (iss_valid) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        if (state_d == ST_CLEAR) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        ra       = '0;
        zero_hit = 1'b0;
        fwd_hit  = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
        rd_pending = '0;
`endif
        for (int i = 0; i < NREAD; i++) begin
            ra       = readaddr[i*ADDR_W +: ADDR_W];
            zero_hit = (ZERO_REG != 0) && (ra == '0);
            fwd_hit  = we && (writeaddr == ra);
            if (zero_hit || is_clear) begin
                readdata[i*DATA_W +: DATA_W] = '0;
            end else if (fwd_hit) begin
                readdata[i*DATA_W +: DATA_W] = writedata;
            end else begin
                readdata[i*DATA_W +: DATA_W] = mem_q[ra];
            end
`ifdef REGFILE_SCOREBOARD_EN
            rd_pending[i] = pend_q[ra] && !(!zero_hit && !is_clear && fwd_hit);
`endif
        end
    end

endmodule
